alu_ctrl_seq: RTL and testbench
===============================

# alu_ctrl_seq

Registered, parametrised ALU-control stage for the pipelined MIPS core, sitting on the ID/EX boundary. Decodes the main-decoder ALU opcode and the R-type function field into an ALU control word. Registers the result into EX. Sequences multi-cycle operations (multiply, divide) with a fixed-latency countdown, raising a stall to the hazard unit while one is in flight.

## Interface
Parameters:
- OPW, 3: width of main-decoder ALU opcode
- FW, 4: width of R-type function field
- CW, 4: width of ALU control word
- MUL_LAT, 4: cycles from accept to result for MUL; legal range 2..255
- DIV_LAT, 8: cycles from accept to result for DIV; legal range 2..255

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- id_valid  in  1  operation presented by ID this cycle
- alu_op  in  OPW  main-decoder ALU opcode
- func  in  FW  R-type function field
- flush  in  1  kill the in-flight operation (branch/exception)
- ex_valid  out  1  ex_aluctl is valid for EX this cycle
- ex_aluctl  out  CW  ALU control word
- ex_multi  out  1  result comes from the multi-cycle unit (MUL/DIV)
- illegal  out  1  the accepted operation had an undefined encoding
- busy  out  1  multi-cycle operation in flight; ID must stall and hold its inputs

## Operation
- Decode (combinational, internal):
  - alu_op==0 (R-type):
    - func 0..6 -> ctl = func
    - func 8 -> MUL (ctl 7)
    - func 9 -> DIV (ctl 8)
    - all other values -> ctl 0, illegal
  - alu_op 1..6 -> ctl = alu_op-1
  - alu_op 7 -> ctl 0, illegal
  - ctl is zero-extended to CW.
- States: IDLE, MULTI.
- IDLE:
  - Accept when id_valid && !flush.
  - Single-cycle op: register ctl, ex_valid=1, ex_multi=0, illegal per decode; stay in IDLE.
  - MUL/DIV: register ctl, ex_multi=1, load cnt = LAT-2, go to MULTI; ex_valid stays 0.
- MULTI:
  - busy=1; ex_aluctl held; id_valid ignored.
  - When cnt==0: ex_valid=1 on the next edge, return to IDLE.
  - Otherwise cnt decrements.
- Counter: 8 bits, never wraps; it only loads in IDLE and decrements in MULTI.
- flush:
  - Highest priority after rst.
  - On the next edge: state IDLE, ex_valid=0, busy=0, illegal=0, cnt=0.
  - Any accept at the same edge is dropped.
- ex_valid on single-cycle ops is a one-cycle pulse per accepted op. Back-to-back accepts give continuous ex_valid.
- An illegal op still produces ex_valid with ctl 0. EX treats it as ADD; the exception logic samples illegal.

## Timing
- Reset values: ex_valid 0, ex_aluctl 0, ex_multi 0, illegal 0, busy 0, state IDLE, cnt 0. rst mid-MULTI aborts identically to reset.
- All outputs are registered; no combinational input-to-output path.
- Single-cycle op accepted at edge N: ex_valid=1 during cycle N+1.
- Multi-cycle op accepted at edge N:
  - busy=1 during cycles N+1 .. N+LAT-1.
  - ex_valid=1 and busy=0 during cycle N+LAT.
  - A new op presented in cycle N+LAT is accepted at that edge (zero bubble).
- ex_valid is 0 during MULTI.
- After the final ex_valid, ex_aluctl holds its value until the next accept.

## Structure
- Shared package alu_pkg holds:
  - ALU control constants: ALU_ADD..ALU_DIV
  - function codes: FN_MUL=8, FN_DIV=9
  - the state enum {IDLE, MULTI}
  - the decode function
- One sub-module is natural: alu_ctrl_decode, purely combinational, (alu_op, func) -> (ctl, is_multi, is_div, illegal). It is reused by the single-cycle core.
- The top level holds the FSM, the countdown counter and the output registers.

## Test plan
- Reset, then R-type func=2 with id_valid for 1 cycle -> next cycle ex_valid=1, ex_aluctl=2, busy=0; following cycle ex_valid=0.
- alu_op=3,4,5 on three consecutive cycles -> ex_aluctl 2,3,4 on three consecutive cycles with ex_valid continuously high.
- MUL (func=8), MUL_LAT=4, accept at edge 0 -> busy high cycles 1..3; ex_valid=1, ex_aluctl=7, ex_multi=1 in cycle 4; an ADD presented in cycle 4 appears at cycle 5.
- DIV (func=9), DIV_LAT=8, flush at cycle 3 -> cycle 4: busy=0, ex_valid=0; no ex_valid at cycle 8.
- func=12 on R-type -> ex_valid=1, ex_aluctl=0, illegal=1; alu_op=7 gives the same result.
- rst asserted mid-MUL together with id_valid -> next cycle all outputs 0, state IDLE; the first op after rst release completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Package     : alu_pkg
// Description : Shared ALU-control definitions: control-word constants,
//               function codes, sequencer state type and the opcode decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Natural width of a control word; wider CW zero-extends it
    localparam int CTL_W = 4;

    localparam logic [CTL_W-1:0] ALU_ADD = 4'd0;
    localparam logic [CTL_W-1:0] ALU_SUB = 4'd1;
    localparam logic [CTL_W-1:0] ALU_AND = 4'd2;
    localparam logic [CTL_W-1:0] ALU_OR  = 4'd3;
    localparam logic [CTL_W-1:0] ALU_XOR = 4'd4;
    localparam logic [CTL_W-1:0] ALU_NOR = 4'd5;
    localparam logic [CTL_W-1:0] ALU_SLT = 4'd6;
    localparam logic [CTL_W-1:0] ALU_MUL = 4'd7;
    localparam logic [CTL_W-1:0] ALU_DIV = 4'd8;

    localparam logic [7:0] FN_MUL = 8'd8;
    localparam logic [7:0] FN_DIV = 8'd9;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        MULTI = 1'b1
    } state_e;

    typedef struct packed {
        logic [CTL_W-1:0] ctl;
        logic             is_multi;
        logic             is_div;
        logic             illegal;
    } decode_t;

    // Opcode 0 selects the R-type function field; opcodes 1..6 map onto the
    // first six ALU operations; anything else is undefined and reads as ADD.
    function automatic decode_t alu_decode(input logic [7:0] op, input logic [7:0] fn);
        decode_t d;
        d = '0;
        if (op == 8'd0) begin
            case (fn)
                8'd0:    d.ctl = ALU_ADD;
                8'd1:    d.ctl = ALU_SUB;
                8'd2:    d.ctl = ALU_AND;
                8'd3:    d.ctl = ALU_OR;
                8'd4:    d.ctl = ALU_XOR;
                8'd5:    d.ctl = ALU_NOR;
                8'd6:    d.ctl = ALU_SLT;
                FN_MUL: begin
                    d.ctl      = ALU_MUL;
                    d.is_multi = 1'b1;
                end
                FN_DIV: begin
                    d.ctl      = ALU_DIV;
                    d.is_multi = 1'b1;
                    d.is_div   = 1'b1;
                end
                default: d.illegal = 1'b1;
            endcase
        end else begin
            case (op)
                8'd1:    d.ctl = ALU_ADD;
                8'd2:    d.ctl = ALU_SUB;
                8'd3:    d.ctl = ALU_AND;
                8'd4:    d.ctl = ALU_OR;
                8'd5:    d.ctl = ALU_XOR;
                8'd6:    d.ctl = ALU_NOR;
                default: d.illegal = 1'b1;
            endcase
        end
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_decode
// Description : Purely combinational ALU-control decoder,
//               (alu_op, func) -> (ctl, is_multi, is_div, illegal).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_ctrl_decode
    import alu_pkg::*;
#(
    parameter int OPW = 3,
    parameter int FW  = 4,
    parameter int CW  = 4
) (
    input  logic [OPW-1:0] alu_op_i,
    input  logic [FW-1:0]  func_i,
    output logic [CW-1:0]  ctl_o,
    output logic           is_multi_o,
    output logic           is_div_o,
    output logic           illegal_o
);

    decode_t dec_w;

    // Inputs are zero-extended to the decoder's fixed argument width
    assign dec_w      = alu_decode(8'(alu_op_i), 8'(func_i));
    assign ctl_o      = CW'(dec_w.ctl);
    assign is_multi_o = dec_w.is_multi;
    assign is_div_o   = dec_w.is_div;
    assign illegal_o  = dec_w.illegal;

endmodule
`default_nettype wire

// File: rtl/alu_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_seq
// Description : Registered ALU-control stage on the ID/EX boundary. Decodes
//               the ALU opcode, registers the control word into EX and
//               sequences fixed-latency MUL/DIV, stalling ID while busy.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_ctrl_seq
    import alu_pkg::*;
#(
    parameter int OPW     = 3,
    parameter int FW      = 4,
    parameter int CW      = 4,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           id_valid,
    input  logic [OPW-1:0] alu_op,
    input  logic [FW-1:0]  func,
    input  logic           flush,
    output logic           ex_valid,
    output logic [CW-1:0]  ex_aluctl,
    output logic           ex_multi,
    output logic           illegal,
    output logic           busy
);

    // The counter is loaded with LAT-2: the accept edge and the final
    // return-to-IDLE edge bracket the countdown.
    localparam logic [7:0] C_MUL_LOAD = 8'(MUL_LAT - 2);
    localparam logic [7:0] C_DIV_LOAD = 8'(DIV_LAT - 2);

    logic [CW-1:0] dec_ctl_w;
    logic          dec_multi_w;
    logic          dec_div_w;
    logic          dec_illegal_w;

    state_e        state_q,    state_d;
    logic [7:0]    cnt_q,      cnt_d;
    logic          ex_valid_q, ex_valid_d;
    logic [CW-1:0] aluctl_q,   aluctl_d;
    logic          multi_q,    multi_d;
    logic          illegal_q,  illegal_d;

    alu_ctrl_decode #(
        .OPW (OPW),
        .FW  (FW),
        .CW  (CW)
    ) u_decode (
        .alu_op_i   (alu_op),
        .func_i     (func),
        .ctl_o      (dec_ctl_w),
        .is_multi_o (dec_multi_w),
        .is_div_o   (dec_div_w),
        .illegal_o  (dec_illegal_w)
    );

    // Next-state: accept in IDLE, count down in MULTI; flush overrides both
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ex_valid_d = 1'b0;
        aluctl_d   = aluctl_q;
        multi_d    = multi_q;
        illegal_d  = illegal_q;

        if (flush) begin
            state_d   = IDLE;
            cnt_d     = 8'd0;
            illegal_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (id_valid) begin
                        aluctl_d  = dec_ctl_w;
                        multi_d   = dec_multi_w;
                        illegal_d = dec_illegal_w;
                        if (dec_multi_w) begin
                            state_d = MULTI;
                            cnt_d   = dec_div_w ? C_DIV_LOAD : C_MUL_LOAD;
                        end else begin
                            ex_valid_d = 1'b1;
                        end
                    end
                end
                MULTI: begin
                    if (cnt_q == 8'd0) begin
                        state_d    = IDLE;
                        ex_valid_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end
            endcase
        end
    end

    // State, counter and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            ex_valid_q <= 1'b0;
            aluctl_q   <= '0;
            multi_q    <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ex_valid_q <= ex_valid_d;
            aluctl_q   <= aluctl_d;
            multi_q    <= multi_d;
            illegal_q  <= illegal_d;
        end
    end

    assign ex_valid  = ex_valid_q;
    assign ex_aluctl = aluctl_q;
    assign ex_multi  = multi_q;
    assign illegal   = illegal_q;
    assign busy      = (state_q == MULTI);

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_ctrl_seq
// Description : Self-checking bench for alu_ctrl_seq. Expected EX results are
//               queued when an op is driven and compared when ex_valid rises.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_ctrl_seq;

    localparam int OPW     = 3;
    localparam int FW      = 4;
    localparam int CW      = 4;
    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 8;

    typedef struct packed {
        logic [CW-1:0] ctl;
        logic          multi;
        logic          ill;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           id_valid;
    logic [OPW-1:0] alu_op;
    logic [FW-1:0]  func;
    logic           flush;
    logic           ex_valid;
    logic [CW-1:0]  ex_aluctl;
    logic           ex_multi;
    logic           illegal;
    logic           busy;

    int   n_vec  = 0;
    int   n_fail = 0;
    exp_t sb_q[$];

    alu_ctrl_seq #(
        .OPW     (OPW),
        .FW      (FW),
        .CW      (CW),
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .id_valid  (id_valid),
        .alu_op    (alu_op),
        .func      (func),
        .flush     (flush),
        .ex_valid  (ex_valid),
        .ex_aluctl (ex_aluctl),
        .ex_multi  (ex_multi),
        .illegal   (illegal),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Scoreboard: every ex_valid cycle must match the oldest queued result
    always @(negedge clk) begin
        if (ex_valid === 1'b1) begin
            exp_t e;
            n_vec = n_vec + 1;
            if (sb_q.size() == 0) begin
                n_fail = n_fail + 1;
                $display("FAIL sb_unexpected: ex_valid=1 ctl=%0d with nothing expected", ex_aluctl);
            end else begin
                e = sb_q.pop_front();
                if (ex_aluctl !== e.ctl || ex_multi !== e.multi || illegal !== e.ill) begin
                    n_fail = n_fail + 1;
                    $display("FAIL sb_result: got ctl=%0d multi=%b ill=%b, want ctl=%0d multi=%b ill=%b",
                             ex_aluctl, ex_multi, illegal, e.ctl, e.multi, e.ill);
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [OPW-1:0] op, input logic [FW-1:0] fn);
        id_valid = v;
        alu_op   = op;
        func     = fn;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; drive(1'b0, '0, '0);
        repeat (2) @(negedge clk);
        n_vec = n_vec + 1;
        if ({ex_valid, ex_aluctl, ex_multi, illegal, busy} !== '0) begin
            n_fail = n_fail + 1;
            $display("FAIL reset: outputs=%b, want all zero", {ex_valid, ex_aluctl, ex_multi, illegal, busy});
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        drive(1'b1, 3'd0, 4'd2); sb_q.push_back('{ctl: 4'd2, multi: 1'b0, ill: 1'b0});
        @(negedge clk);
        drive(1'b0, '0, '0);
        n_vec = n_vec + 1;
        if (ex_valid !== 1'b1 || busy !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL single_pulse: ex_valid=%b busy=%b, want 1 0", ex_valid, busy);
        end
        @(negedge clk);
        n_vec = n_vec + 1;
        if (ex_valid !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL single_drop: ex_valid=%b, want 0", ex_valid);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 3; i <= 5; i++) begin
            drive(1'b1, 3'(i), 4'd0);
            sb_q.push_back('{ctl: 4'(i - 1), multi: 1'b0, ill: 1'b0});
            @(negedge clk);
            if (i > 3) begin
                n_vec = n_vec + 1;
                if (ex_valid !== 1'b1) begin
                    n_fail = n_fail + 1;
                    $display("FAIL b2b_cont: ex_valid=%b at op %0d, want 1", ex_valid, i);
                end
            end
        end
        drive(1'b0, '0, '0);
        @(negedge clk);
        n_vec = n_vec + 1;
        if (ex_valid !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL b2b_end: ex_valid=%b, want 0", ex_valid);
        end
    endtask

    task automatic test_mul();
        // MUL held on the ID inputs the whole time it is in flight
        drive(1'b1, 3'd0, 4'd8); sb_q.push_back('{ctl: 4'd7, multi: 1'b1, ill: 1'b0});
        for (int k = 1; k <= MUL_LAT - 1; k++) begin
            @(negedge clk);
            n_vec = n_vec + 1;
            if (busy !== 1'b1 || ex_valid !== 1'b0 || ex_aluctl !== 4'd7) begin
                n_fail = n_fail + 1;
                $display("FAIL mul_busy: cycle %0d busy=%b ex_valid=%b ctl=%0d, want 1 0 7", k, busy, ex_valid, ex_aluctl);
            end
        end
        @(negedge clk);
        n_vec = n_vec + 1;
        if (busy !== 1'b0 || ex_valid !== 1'b1) begin
            n_fail = n_fail + 1;
            $display("FAIL mul_done: busy=%b ex_valid=%b, want 0 1", busy, ex_valid);
        end
        drive(1'b1, 3'd1, 4'd0); sb_q.push_back('{ctl: 4'd0, multi: 1'b0, ill: 1'b0});
        @(negedge clk);
        drive(1'b0, '0, '0);
        n_vec = n_vec + 1;
        if (ex_valid !== 1'b1 || ex_multi !== 1'b0 || busy !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL mul_zero_bubble: ex_valid=%b multi=%b busy=%b, want 1 0 0", ex_valid, ex_multi, busy);
        end
        @(negedge clk);
    endtask

    task automatic test_div_full();
        int busy_cnt;
        int waited;
        busy_cnt = 0;
        waited   = 0;
        drive(1'b1, 3'd0, 4'd9); sb_q.push_back('{ctl: 4'd8, multi: 1'b1, ill: 1'b0});
        @(negedge clk);
        drive(1'b0, '0, '0);
        while (ex_valid !== 1'b1 && waited < 40) begin
            if (busy === 1'b1) busy_cnt++;
            waited++;
            @(negedge clk);
        end
        n_vec = n_vec + 1;
        if (ex_valid !== 1'b1 || busy_cnt != DIV_LAT - 1) begin
            n_fail = n_fail + 1;
            $display("FAIL div_latency: ex_valid=%b busy_cycles=%0d, want 1 %0d", ex_valid, busy_cnt, DIV_LAT - 1);
        end
        @(negedge clk);
    endtask

    task automatic test_div_flush();
        drive(1'b1, 3'd0, 4'd9);
        @(negedge clk);
        drive(1'b0, '0, '0);
        @(negedge clk);
        @(negedge clk);
        n_vec = n_vec + 1;
        if (busy !== 1'b1) begin
            n_fail = n_fail + 1;
            $display("FAIL div_busy: busy=%b in cycle 3, want 1", busy);
        end
        // Flush with a competing op presented: the op must be dropped
        flush = 1'b1; drive(1'b1, 3'd2, 4'd0);
        @(negedge clk);
        flush = 1'b0; drive(1'b0, '0, '0);
        n_vec = n_vec + 1;
        if (busy !== 1'b0 || ex_valid !== 1'b0 || illegal !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL div_flush: busy=%b ex_valid=%b illegal=%b, want 0 0 0", busy, ex_valid, illegal);
        end
        for (int c = 5; c <= DIV_LAT + 1; c++) begin
            @(negedge clk);
            n_vec = n_vec + 1;
            if (ex_valid !== 1'b0 || busy !== 1'b0) begin
                n_fail = n_fail + 1;
                $display("FAIL div_after_flush: cycle %0d ex_valid=%b busy=%b, want 0 0", c, ex_valid, busy);
            end
        end
    endtask

    task automatic test_illegal();
        drive(1'b1, 3'd0, 4'd12); sb_q.push_back('{ctl: 4'd0, multi: 1'b0, ill: 1'b1});
        @(negedge clk);
        drive(1'b1, 3'd7, 4'd0); sb_q.push_back('{ctl: 4'd0, multi: 1'b0, ill: 1'b1});
        n_vec = n_vec + 1;
        if (ex_valid !== 1'b1 || illegal !== 1'b1 || ex_aluctl !== 4'd0) begin
            n_fail = n_fail + 1;
            $display("FAIL illegal_func: ex_valid=%b illegal=%b ctl=%0d, want 1 1 0", ex_valid, illegal, ex_aluctl);
        end
        @(negedge clk);
        drive(1'b1, 3'd0, 4'd6); sb_q.push_back('{ctl: 4'd6, multi: 1'b0, ill: 1'b0});
        n_vec = n_vec + 1;
        if (ex_valid !== 1'b1 || illegal !== 1'b1) begin
            n_fail = n_fail + 1;
            $display("FAIL illegal_op7: ex_valid=%b illegal=%b, want 1 1", ex_valid, illegal);
        end
        @(negedge clk);
        drive(1'b0, '0, '0);
        n_vec = n_vec + 1;
        if (illegal !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL illegal_clear: illegal=%b after legal op, want 0", illegal);
        end
        @(negedge clk);
    endtask

    task automatic test_rst_mid();
        drive(1'b1, 3'd0, 4'd8);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_vec = n_vec + 1;
        if ({ex_valid, ex_aluctl, ex_multi, illegal, busy} !== '0) begin
            n_fail = n_fail + 1;
            $display("FAIL rst_mid: outputs=%b, want all zero", {ex_valid, ex_aluctl, ex_multi, illegal, busy});
        end
        rst = 1'b0; drive(1'b1, 3'd2, 4'd0); sb_q.push_back('{ctl: 4'd1, multi: 1'b0, ill: 1'b0});
        @(negedge clk);
        drive(1'b0, '0, '0);
        n_vec = n_vec + 1;
        if (ex_valid !== 1'b1 || ex_aluctl !== 4'd1 || busy !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL rst_recover: ex_valid=%b ctl=%0d busy=%b, want 1 1 0", ex_valid, ex_aluctl, busy);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_mul();
        test_div_full();
        test_div_flush();
        test_illegal();
        test_rst_mid();
        repeat (2) @(negedge clk);
        n_vec = n_vec + 1;
        if (sb_q.size() != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL sb_drain: %0d results never produced, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
